// File: rtl/peripheral_ahb4_arb_pkg.sv
// Shared types for the two-master AHB-Lite SPRAM arbiter: transfer encodings,
// data-phase owner states and the captured address-phase record.
package peripheral_ahb4_arb_pkg;

  localparam int AHB_ADDR_W = 64;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    D_NONE = 2'd0,
    D_M0   = 2'd1,
    D_M1   = 2'd2
  } dphase_e;

  typedef struct packed {
    logic [AHB_ADDR_W-1:0] addr;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic [1:0]            trans;
    logic                  lock;
  } ahb_addr_phase_t;

endpackage

// File: rtl/peripheral_ahb4_spram_arbiter_if.sv
// One AHB-Lite link; the arbiter uses the slave view towards each master and
// the master view towards the SPRAM.
interface peripheral_ahb4_spram_arbiter_if #(
  parameter int PLEN = 64,
  parameter int XLEN = 64
);
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HREADYOUT;
  logic            HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/peripheral_ahb4_arb_hold.sv
// Per-master address-phase hold: captures a request that lost arbitration and
// presents it (or the live phase when nothing is held) to the grant logic.
module peripheral_ahb4_arb_hold
  import peripheral_ahb4_arb_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  ahb_addr_phase_t live_i,
  input  logic            live_req_i,
  input  logic            issue_i,
  output logic            pend_o,
  output logic            req_o,
  output ahb_addr_phase_t phase_o
);

  logic            pend_q, pend_d;
  ahb_addr_phase_t held_q, held_d;

  always_comb begin
    pend_d = pend_q;
    held_d = held_q;
    if (issue_i) begin
      pend_d = 1'b0;
    end else if (live_req_i && !pend_q) begin
      pend_d = 1'b1;
      held_d = live_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      held_q <= '0;
    end else begin
      pend_q <= pend_d;
      held_q <= held_d;
    end
  end

  assign pend_o  = pend_q;
  assign req_o   = live_req_i | pend_q;
  assign phase_o = pend_q ? held_q : live_i;

endmodule

// File: rtl/peripheral_ahb4_spram_arbiter.sv
// Round-robin two-master AHB-Lite arbiter in front of a single-port SPRAM;
// losers are held and replayed, locked/SEQ bursts keep the grant.
module peripheral_ahb4_spram_arbiter
  import peripheral_ahb4_arb_pkg::*;
#(
  parameter int PLEN = 64,
  parameter int XLEN = 64
) (
  input logic HCLK,
  input logic HRESETn,
  peripheral_ahb4_spram_arbiter_if.slave  m0,
  peripheral_ahb4_spram_arbiter_if.slave  m1,
  peripheral_ahb4_spram_arbiter_if.master s
);

  ahb_addr_phase_t live_ph [2];
  ahb_addr_phase_t sel_ph  [2];
  ahb_addr_phase_t out_ph;
  ahb_addr_phase_t out_q;
  logic [1:0]      live_sel, live_req, req, pend, issue_m;
  logic            last_q, lock_q;
  dphase_e         dph_q;
  logic            own_seq, hold_own, gnt, issue, fwd, drive;

  always_comb begin
    live_ph[0] = '{addr: AHB_ADDR_W'(m0.HADDR), write: m0.HWRITE, size: m0.HSIZE,
                   burst: m0.HBURST, prot: m0.HPROT, trans: m0.HTRANS, lock: m0.HMASTLOCK};
    live_ph[1] = '{addr: AHB_ADDR_W'(m1.HADDR), write: m1.HWRITE, size: m1.HSIZE,
                   burst: m1.HBURST, prot: m1.HPROT, trans: m1.HTRANS, lock: m1.HMASTLOCK};
  end

  assign live_sel = {m1.HSEL & m1.HREADY, m0.HSEL & m0.HREADY};
  assign live_req = live_sel & {m1.HTRANS[1], m0.HTRANS[1]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_hold
    peripheral_ahb4_arb_hold u_hold (
      .clk_i      (HCLK),
      .rst_ni     (HRESETn),
      .live_i     (live_ph[gi]),
      .live_req_i (live_req[gi]),
      .issue_i    (issue_m[gi]),
      .pend_o     (pend[gi]),
      .req_o      (req[gi]),
      .phase_o    (sel_ph[gi])
    );
  end

  // The last issuer keeps the bus through SEQ/BUSY beats and while it keeps
  // HMASTLOCK asserted after a locked transfer; otherwise alternate.
  always_comb begin
    own_seq  = live_sel[last_q] &
               ((live_ph[last_q].trans == HTRANS_SEQ) || (live_ph[last_q].trans == HTRANS_BUSY));
    hold_own = (lock_q & live_ph[last_q].lock) | own_seq;
    if (hold_own)            gnt = last_q;
    else if (req[0] & req[1]) gnt = ~last_q;
    else                     gnt = req[1];
    issue   = HRESETn & s.HREADYOUT & req[gnt];
    fwd     = HRESETn & s.HREADYOUT & hold_own & ~req[gnt] & live_sel[gnt];
    drive   = issue | fwd;
    issue_m = issue ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  end

  assign out_ph = drive ? sel_ph[gnt] : out_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_q <= 1'b1;
      lock_q <= 1'b0;
      dph_q  <= D_NONE;
      out_q  <= '0;
    end else begin
      out_q <= out_ph;
      if (issue) begin
        last_q <= gnt;
        lock_q <= sel_ph[gnt].lock;
      end
      if (s.HREADYOUT) dph_q <= issue ? (gnt ? D_M1 : D_M0) : D_NONE;
    end
  end

  assign s.HSEL      = drive;
  assign s.HTRANS    = drive ? out_ph.trans : HTRANS_IDLE;
  assign s.HADDR     = PLEN'(out_ph.addr);
  assign s.HWRITE    = out_ph.write;
  assign s.HSIZE     = out_ph.size;
  assign s.HBURST    = out_ph.burst;
  assign s.HPROT     = out_ph.prot;
  assign s.HMASTLOCK = out_ph.lock;
  assign s.HREADY    = s.HREADYOUT;
  assign s.HWDATA    = (dph_q == D_M0) ? m0.HWDATA :
                       (dph_q == D_M1) ? m1.HWDATA : {XLEN{1'b0}};

  assign m0.HRDATA    = s.HRDATA;
  assign m1.HRDATA    = s.HRDATA;
  assign m0.HREADYOUT = (dph_q == D_M0) ? s.HREADYOUT : ~pend[0];
  assign m1.HREADYOUT = (dph_q == D_M1) ? s.HREADYOUT : ~pend[1];
  assign m0.HRESP     = (dph_q == D_M0) & s.HRESP;
  assign m1.HRESP     = (dph_q == D_M1) & s.HRESP;

endmodule

// File: tb/tb_peripheral_ahb4_spram_arbiter.sv
// Directed bench for the two-master SPRAM arbiter with a small AHB memory
// model that can insert wait states and an ERROR response.
module tb_peripheral_ahb4_spram_arbiter;
  import peripheral_ahb4_arb_pkg::*;

  localparam logic [2:0] HBURST_INCR4 = 3'b011;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  peripheral_ahb4_spram_arbiter_if #(.PLEN(64), .XLEN(64)) m0_if ();
  peripheral_ahb4_spram_arbiter_if #(.PLEN(64), .XLEN(64)) m1_if ();
  peripheral_ahb4_spram_arbiter_if #(.PLEN(64), .XLEN(64)) s_if ();

  peripheral_ahb4_spram_arbiter #(.PLEN(64), .XLEN(64)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if)
  );

  assign m0_if.HREADY = m0_if.HREADYOUT;
  assign m1_if.HREADY = m1_if.HREADYOUT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory slave model
  logic [63:0] mem [64];
  logic        sd_act, sd_wr, sd_err, sd_errph;
  logic [5:0]  sd_idx;
  int          sd_wait;
  int          cfg_wait;
  logic        cfg_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_act   <= 1'b0;
      sd_wr    <= 1'b0;
      sd_err   <= 1'b0;
      sd_errph <= 1'b0;
      sd_idx   <= '0;
      sd_wait  <= 0;
    end else if (s_if.HREADYOUT) begin
      if (sd_act && sd_wr && !sd_err) mem[sd_idx] <= s_if.HWDATA;
      sd_act   <= s_if.HSEL && s_if.HTRANS[1] && s_if.HREADY;
      sd_wr    <= s_if.HWRITE;
      sd_idx   <= s_if.HADDR[8:3];
      sd_wait  <= (s_if.HSEL && s_if.HTRANS[1]) ? cfg_wait : 0;
      sd_err   <= (s_if.HSEL && s_if.HTRANS[1]) ? cfg_err : 1'b0;
      sd_errph <= 1'b0;
    end else if (sd_wait != 0) begin
      sd_wait <= sd_wait - 1;
    end else begin
      sd_errph <= 1'b1;
    end
  end

  always_comb begin
    s_if.HRDATA    = sd_act ? mem[sd_idx] : 64'd0;
    s_if.HREADYOUT = 1'b1;
    s_if.HRESP     = 1'b0;
    if (sd_act && sd_wait != 0) begin
      s_if.HREADYOUT = 1'b0;
    end else if (sd_act && sd_err) begin
      s_if.HREADYOUT = sd_errph;
      s_if.HRESP     = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drv(input int m, input logic [1:0] trans, input logic wr,
                     input logic [63:0] addr, input logic [2:0] burst, input logic lock);
    if (m == 0) begin
      m0_if.HSEL = (trans != HTRANS_IDLE); m0_if.HTRANS = trans; m0_if.HWRITE = wr;
      m0_if.HADDR = addr; m0_if.HBURST = burst; m0_if.HMASTLOCK = lock;
    end else begin
      m1_if.HSEL = (trans != HTRANS_IDLE); m1_if.HTRANS = trans; m1_if.HWRITE = wr;
      m1_if.HADDR = addr; m1_if.HBURST = burst; m1_if.HMASTLOCK = lock;
    end
  endtask

  task automatic idle_both();
    drv(0, HTRANS_IDLE, 1'b0, 64'd0, HBURST_SINGLE, 1'b0);
    drv(1, HTRANS_IDLE, 1'b0, 64'd0, HBURST_SINGLE, 1'b0);
  endtask

  task automatic do_reset();
    idle_both();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  logic [63:0] rr_exp [6];
  logic [63:0] a0, a1;
  logic        r0, r1;
  int          stall_cnt;
  logic [1:0]  wait_rdy, wait_resp;

  initial begin
    n_chk = 0; n_err = 0;
    cfg_wait = 0; cfg_err = 1'b0;
    m0_if.HSIZE = 3'b011; m0_if.HPROT = 4'b0011; m0_if.HWDATA = '0;
    m1_if.HSIZE = 3'b011; m1_if.HPROT = 4'b0011; m1_if.HWDATA = '0;
    idle_both();
    rst_n = 1'b0;
    step();
    step();

    // reset state
    mid();
    check_eq("rst_hsel", s_if.HSEL, 1'b0);
    check_eq("rst_htrans", s_if.HTRANS, HTRANS_IDLE);
    check_eq("rst_haddr", s_if.HADDR, 64'd0);
    check_eq("rst_hwdata", s_if.HWDATA, 64'd0);
    check_eq("rst_m0_rdy", m0_if.HREADYOUT, 1'b1);
    check_eq("rst_m1_rdy", m1_if.HREADYOUT, 1'b1);
    check_eq("rst_m0_resp", m0_if.HRESP, 1'b0);
    rst_n = 1'b1;
    step();

    // single master write then read
    drv(0, HTRANS_NONSEQ, 1'b1, 64'h10, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t1_wr_haddr", s_if.HADDR, 64'h10);
    check_eq("t1_wr_htrans", s_if.HTRANS, HTRANS_NONSEQ);
    check_eq("t1_wr_rdy", m0_if.HREADYOUT, 1'b1);
    step();
    m0_if.HWDATA = 64'hDEADBEEF_00000001;
    drv(0, HTRANS_NONSEQ, 1'b0, 64'h10, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t1_hwdata", s_if.HWDATA, 64'hDEADBEEF_00000001);
    check_eq("t1_rd_hwrite", s_if.HWRITE, 1'b0);
    check_eq("t1_rd_rdy", m0_if.HREADYOUT, 1'b1);
    step();
    drv(0, HTRANS_IDLE, 1'b0, 64'h0, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t1_rdata", m0_if.HRDATA, 64'hDEADBEEF_00000001);
    check_eq("t1_data_rdy", m0_if.HREADYOUT, 1'b1);
    step();

    // contention after reset
    do_reset();
    drv(0, HTRANS_NONSEQ, 1'b1, 64'h20, HBURST_SINGLE, 1'b0);
    drv(1, HTRANS_NONSEQ, 1'b1, 64'h28, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t2_first_haddr", s_if.HADDR, 64'h20);
    check_eq("t2_m1_rdy_c0", m1_if.HREADYOUT, 1'b1);
    step();
    m0_if.HWDATA = 64'hA; m1_if.HWDATA = 64'hB;
    idle_both();
    mid();
    check_eq("t2_m1_stall", m1_if.HREADYOUT, 1'b0);
    check_eq("t2_second_haddr", s_if.HADDR, 64'h28);
    check_eq("t2_second_htrans", s_if.HTRANS, HTRANS_NONSEQ);
    check_eq("t2_hwdata_m0", s_if.HWDATA, 64'hA);
    step();
    drv(0, HTRANS_NONSEQ, 1'b0, 64'h20, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t2_m1_rdy_c2", m1_if.HREADYOUT, 1'b1);
    check_eq("t2_hwdata_m1", s_if.HWDATA, 64'hB);
    check_eq("t2_rd_haddr", s_if.HADDR, 64'h20);
    step();
    drv(0, HTRANS_NONSEQ, 1'b0, 64'h28, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t2_rdata_a", m0_if.HRDATA, 64'hA);
    step();
    drv(0, HTRANS_IDLE, 1'b0, 64'h0, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t2_rdata_b", m0_if.HRDATA, 64'hB);
    step();

    // round-robin, both masters requesting every cycle
    do_reset();
    rr_exp[0] = 64'h100; rr_exp[1] = 64'h200; rr_exp[2] = 64'h108;
    rr_exp[3] = 64'h208; rr_exp[4] = 64'h110; rr_exp[5] = 64'h210;
    a0 = 64'h100; a1 = 64'h200;
    drv(0, HTRANS_NONSEQ, 1'b0, a0, HBURST_SINGLE, 1'b0);
    drv(1, HTRANS_NONSEQ, 1'b0, a1, HBURST_SINGLE, 1'b0);
    for (int i = 0; i < 6; i++) begin
      mid();
      check_eq($sformatf("t3_issue%0d", i), s_if.HADDR, rr_exp[i]);
      r0 = m0_if.HREADYOUT;
      r1 = m1_if.HREADYOUT;
      step();
      if (r0) begin a0 = a0 + 64'd8; drv(0, HTRANS_NONSEQ, 1'b0, a0, HBURST_SINGLE, 1'b0); end
      if (r1) begin a1 = a1 + 64'd8; drv(1, HTRANS_NONSEQ, 1'b0, a1, HBURST_SINGLE, 1'b0); end
    end
    idle_both();
    repeat (3) step();

    // locked INCR4 burst from M1, M0 arrives during beat 2
    do_reset();
    stall_cnt = 0;
    drv(1, HTRANS_NONSEQ, 1'b0, 64'h40, HBURST_INCR4, 1'b1);
    mid();
    check_eq("t4_beat1", s_if.HADDR, 64'h40);
    step();
    drv(1, HTRANS_SEQ, 1'b0, 64'h48, HBURST_INCR4, 1'b1);
    drv(0, HTRANS_NONSEQ, 1'b0, 64'h80, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t4_beat2", s_if.HADDR, 64'h48);
    if (!m0_if.HREADYOUT) stall_cnt++;
    step();
    drv(0, HTRANS_IDLE, 1'b0, 64'h0, HBURST_SINGLE, 1'b0);
    drv(1, HTRANS_SEQ, 1'b0, 64'h50, HBURST_INCR4, 1'b1);
    mid();
    check_eq("t4_beat3", s_if.HADDR, 64'h50);
    if (!m0_if.HREADYOUT) stall_cnt++;
    step();
    drv(1, HTRANS_SEQ, 1'b0, 64'h58, HBURST_INCR4, 1'b1);
    mid();
    check_eq("t4_beat4", s_if.HADDR, 64'h58);
    check_eq("t4_beat4_htrans", s_if.HTRANS, HTRANS_SEQ);
    if (!m0_if.HREADYOUT) stall_cnt++;
    step();
    drv(1, HTRANS_IDLE, 1'b0, 64'h0, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t4_m0_haddr", s_if.HADDR, 64'h80);
    check_eq("t4_m0_hsel", s_if.HSEL, 1'b1);
    if (!m0_if.HREADYOUT) stall_cnt++;
    step();
    mid();
    if (!m0_if.HREADYOUT) stall_cnt++;
    check_eq("t4_m0_stall_cycles", stall_cnt, 3);
    step();

    // slave wait states then ERROR on an M0 read, M1 held meanwhile
    do_reset();
    cfg_wait = 2; cfg_err = 1'b1;
    drv(0, HTRANS_NONSEQ, 1'b0, 64'h10, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t5_issue", s_if.HADDR, 64'h10);
    step();
    cfg_wait = 0; cfg_err = 1'b0;
    drv(0, HTRANS_IDLE, 1'b0, 64'h0, HBURST_SINGLE, 1'b0);
    drv(1, HTRANS_NONSEQ, 1'b0, 64'h28, HBURST_SINGLE, 1'b0);
    wait_rdy  = 2'b00;
    wait_resp = 2'b00;
    for (int k = 0; k < 4; k++) begin
      mid();
      wait_rdy  = (k == 3) ? 2'b01 : 2'b00;
      wait_resp = (k >= 2) ? 2'b01 : 2'b00;
      check_eq($sformatf("t5_m0_rdy%0d", k), m0_if.HREADYOUT, wait_rdy[0]);
      check_eq($sformatf("t5_m0_resp%0d", k), m0_if.HRESP, wait_resp[0]);
      check_eq($sformatf("t5_m1_resp%0d", k), m1_if.HRESP, 1'b0);
      if (k == 0) check_eq("t5_no_issue_hsel", s_if.HSEL, 1'b0);
      if (k == 3) check_eq("t5_m1_held_issue", s_if.HADDR, 64'h28);
      step();
      if (k == 0) drv(1, HTRANS_IDLE, 1'b0, 64'h0, HBURST_SINGLE, 1'b0);
    end
    step();

    // reset while M1 is held
    do_reset();
    drv(0, HTRANS_NONSEQ, 1'b1, 64'h20, HBURST_SINGLE, 1'b0);
    drv(1, HTRANS_NONSEQ, 1'b1, 64'h28, HBURST_SINGLE, 1'b0);
    step();
    idle_both();
    mid();
    check_eq("t6_pre_stall", m1_if.HREADYOUT, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_htrans", s_if.HTRANS, HTRANS_IDLE);
    check_eq("t6_rst_hsel", s_if.HSEL, 1'b0);
    check_eq("t6_rst_m1_rdy", m1_if.HREADYOUT, 1'b1);
    check_eq("t6_rst_haddr", s_if.HADDR, 64'd0);
    check_eq("t6_rst_hwdata", s_if.HWDATA, 64'd0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mid();
    check_eq("t6_pend_cleared", s_if.HSEL, 1'b0);
    step();
    drv(0, HTRANS_NONSEQ, 1'b0, 64'h30, HBURST_SINGLE, 1'b0);
    drv(1, HTRANS_NONSEQ, 1'b0, 64'h38, HBURST_SINGLE, 1'b0);
    mid();
    check_eq("t6_post_gnt_m0", s_if.HADDR, 64'h30);
    step();
    idle_both();
    mid();
    check_eq("t6_post_m1", s_if.HADDR, 64'h38);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
